decode_issue_stage: RTL and testbench



---
 rtl/decode_issue_stage.sv | 172 +++++++++++++++++
 tb/tb_decode_issue_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file, per-register pending-write scoreboard and a registered EX slot.
// Optional DECODE_WB_BYPASS_EN forwards same-cycle writeback data into the decoded operands.
module decode_issue_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             if_valid_i,
    input  logic [31:0]      if_instr_i,
    input  logic [XLEN-1:0]  if_pc4_i,
    output logic             id_ready_o,
    input  logic             ctl_uses_rs_i,
    input  logic             ctl_uses_rt_i,
    input  logic             ctl_regwrite_i,
    input  logic [AW-1:0]    ctl_dest_i,
    input  logic             flush_i,
    input  logic             wb_we_i,
    input  logic [AW-1:0]    wb_addr_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic             sb_release_i,
    input  logic [AW-1:0]    sb_release_addr_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [XLEN-1:0]  ex_rs_val_o,
    output logic [XLEN-1:0]  ex_rt_val_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [XLEN-1:0]  ex_br_target_o,
    output logic [AW-1:0]    ex_dest_o,
    output logic             ex_regwrite_o,
    output logic [XLEN-1:0]  ex_pc4_o,
    output logic             sb_err_o
);

    localparam logic [CNT_W:0] CMAX = {1'b0, {CNT_W{1'b1}}};

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [CNT_W-1:0] cnt_q  [NREGS];
    logic [CNT_W-1:0] cnt_d  [NREGS];
    logic             sb_err_q, sb_err_d;

    logic             ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]  ex_rs_val_q, ex_rt_val_q, ex_imm_q, ex_br_target_q, ex_pc4_q;
    logic [AW-1:0]    ex_dest_q;
    logic             ex_regwrite_q;

    logic [AW-1:0]    rs_a, rt_a;
    logic             ex_pend_wr;
    logic             rs_busy, rt_busy;
    logic             raw_hazard, sat, slot_blocked, transfer;
    logic [CNT_W:0]   sat_sum;
    logic [XLEN-1:0]  rs_val, rt_val, imm_sext;
    logic             inc_en, wb_dec, rel_dec;

    assign rs_a       = AW'(if_instr_i[25:21]);
    assign rt_a       = AW'(if_instr_i[20:16]);
    // The slot's write is not yet counted in cnt_q, so it is checked separately.
    assign ex_pend_wr = ex_valid_q & ex_regwrite_q;

    always_comb begin
        rs_busy = (cnt_q[rs_a] != '0);
        rt_busy = (cnt_q[rt_a] != '0);
`ifdef DECODE_WB_BYPASS_EN
        if (wb_we_i && wb_addr_i == rs_a && cnt_q[rs_a] == CNT_W'(1)) rs_busy = 1'b0;
        if (wb_we_i && wb_addr_i == rt_a && cnt_q[rt_a] == CNT_W'(1)) rt_busy = 1'b0;
`endif
    end

    assign raw_hazard =
        (ctl_uses_rs_i && rs_a != '0 && (rs_busy || (ex_pend_wr && ex_dest_q == rs_a))) ||
        (ctl_uses_rt_i && rt_a != '0 && (rt_busy || (ex_pend_wr && ex_dest_q == rt_a)));

    assign sat_sum = {1'b0, cnt_q[ctl_dest_i]}
                   + (CNT_W+1)'(ex_pend_wr && ex_dest_q == ctl_dest_i);
    assign sat     = ctl_regwrite_i && (sat_sum >= CMAX);

    // Handshake: EX takes the slot on a cycle where ex_valid_o & ex_ready_i;
    // fetch hands over on if_valid_i & id_ready_o & !flush_i.
    assign slot_blocked = ex_valid_q & ~ex_ready_i;
    assign id_ready_o   = ~(slot_blocked | raw_hazard | sat);
    assign transfer     = if_valid_i & id_ready_o & ~flush_i;

    always_comb begin
        rs_val = regs_q[rs_a];
        rt_val = regs_q[rt_a];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_we_i && wb_addr_i == rs_a && rs_a != '0) rs_val = wb_data_i;
        if (wb_we_i && wb_addr_i == rt_a && rt_a != '0) rt_val = wb_data_i;
`endif
    end

    assign imm_sext = {{(XLEN-16){if_instr_i[15]}}, if_instr_i[15:0]};

    // A flushed slot never reaches EX, so it is never counted.
    assign inc_en  = ex_valid_q & ex_ready_i & ex_regwrite_q & ~flush_i & (ex_dest_q != '0);
    assign wb_dec  = wb_we_i & (wb_addr_i != '0);
    assign rel_dec = sb_release_i & (sb_release_addr_i != '0);

    always_comb begin
        sb_err_d = sb_err_q;
        for (int r = 0; r < NREGS; r++) begin
            logic [CNT_W:0] avail;
            logic [1:0]     ndec;
            avail = {1'b0, cnt_q[r]} + (CNT_W+1)'(inc_en && ex_dest_q == AW'(r));
            ndec  = 2'(wb_dec && wb_addr_i == AW'(r)) + 2'(rel_dec && sb_release_addr_i == AW'(r));
            if ((CNT_W+1)'(ndec) > avail) begin
                cnt_d[r] = '0;
                sb_err_d = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(avail - (CNT_W+1)'(ndec));
            end
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (flush_i)         ex_valid_d = 1'b0;
        else if (transfer)   ex_valid_d = 1'b1;
        else if (ex_ready_i) ex_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (wb_we_i && wb_addr_i != '0) regs_q[wb_addr_i] <= wb_data_i;
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
            sb_err_q <= sb_err_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q     <= 1'b0;
            ex_rs_val_q    <= '0;
            ex_rt_val_q    <= '0;
            ex_imm_q       <= '0;
            ex_br_target_q <= '0;
            ex_dest_q      <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_pc4_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            if (transfer) begin
                ex_rs_val_q    <= rs_val;
                ex_rt_val_q    <= rt_val;
                ex_imm_q       <= imm_sext;
                ex_br_target_q <= if_pc4_i + (imm_sext << 2);
                ex_dest_q      <= ctl_dest_i;
                ex_regwrite_q  <= ctl_regwrite_i;
                ex_pc4_q       <= if_pc4_i;
            end
        end
    end

    assign ex_valid_o     = ex_valid_q;
    assign ex_rs_val_o    = ex_rs_val_q;
    assign ex_rt_val_o    = ex_rt_val_q;
    assign ex_imm_o       = ex_imm_q;
    assign ex_br_target_o = ex_br_target_q;
    assign ex_dest_o      = ex_dest_q;
    assign ex_regwrite_o  = ex_regwrite_q;
    assign ex_pc4_o       = ex_pc4_q;
    assign sb_err_o       = sb_err_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: stall/hazard checks plus an EX-side scoreboard of issued payloads.
module tb_decode_issue_stage;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int CNT_W = 2;
  localparam int AW    = 5;
  localparam int PW    = 5*XLEN + AW + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            if_valid = 1'b0;
  logic [31:0]     if_instr = '0;
  logic [XLEN-1:0] if_pc4 = '0;
  logic            id_ready;
  logic            ctl_uses_rs = 1'b0, ctl_uses_rt = 1'b0, ctl_regwrite = 1'b0;
  logic [AW-1:0]   ctl_dest = '0;
  logic            flush = 1'b0;
  logic            wb_we = 1'b0;
  logic [AW-1:0]   wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            sb_release = 1'b0;
  logic [AW-1:0]   sb_release_addr = '0;
  logic            ex_valid;
  logic            ex_ready = 1'b1;
  logic [XLEN-1:0] ex_rs_val, ex_rt_val, ex_imm, ex_br_target, ex_pc4;
  logic [AW-1:0]   ex_dest;
  logic            ex_regwrite;
  logic            sb_err;

  int n_chk = 0;
  int n_fail = 0;
  logic [PW-1:0]   exp_q[$];
  logic [XLEN-1:0] ref_regs [NREGS];

  decode_issue_stage #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc4_i(if_pc4),
    .id_ready_o(id_ready),
    .ctl_uses_rs_i(ctl_uses_rs), .ctl_uses_rt_i(ctl_uses_rt),
    .ctl_regwrite_i(ctl_regwrite), .ctl_dest_i(ctl_dest),
    .flush_i(flush),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .sb_release_i(sb_release), .sb_release_addr_i(sb_release_addr),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_rs_val_o(ex_rs_val), .ex_rt_val_o(ex_rt_val), .ex_imm_o(ex_imm),
    .ex_br_target_o(ex_br_target), .ex_dest_o(ex_dest),
    .ex_regwrite_o(ex_regwrite), .ex_pc4_o(ex_pc4), .sb_err_o(sb_err)
  );

  // clock / reference register file
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) ref_regs[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      ref_regs[wb_addr] <= wb_data;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] opnd(input logic [AW-1:0] s);
    logic [XLEN-1:0] v;
    v = (s == '0) ? '0 : ref_regs[s];
`ifdef DECODE_WB_BYPASS_EN
    if (s != '0 && wb_we && wb_addr == s) v = wb_data;
`endif
    return v;
  endfunction

  task automatic push_expected();
    logic [XLEN-1:0] immv;
    immv = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
    exp_q.push_back({opnd(if_instr[25:21]), opnd(if_instr[20:16]), immv,
                     if_pc4 + (immv << 2), ctl_dest, ctl_regwrite, if_pc4});
  endtask

  // driver tasks
  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                           input logic [31:0] pc4, input logic urs, input logic urt,
                           input logic rw, input logic [4:0] dest);
    if_valid     = 1'b1;
    if_instr     = {6'h23, rs, rt, imm};
    if_pc4       = pc4;
    ctl_uses_rs  = urs;
    ctl_uses_rt  = urt;
    ctl_regwrite = rw;
    ctl_dest     = dest;
  endtask

  task automatic idle();
    if_valid = 1'b0; if_instr = '0; if_pc4 = '0;
    ctl_uses_rs = 1'b0; ctl_uses_rt = 1'b0; ctl_regwrite = 1'b0; ctl_dest = '0;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_addr = a; wb_data = d;
  endtask

  // One clock: check id_ready mid-cycle, record an expected issue, advance past the edge.
  task automatic cycle(input logic exp_rdy, input string tag);
    @(negedge clk);
    chk(tag, 256'(id_ready), 256'(exp_rdy));
    if (exp_rdy && if_valid && !flush) push_expected();
    @(posedge clk); #1;
  endtask

  // scoreboard: compare every payload EX consumes
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        chk("ex_unexpected_valid", 256'(ex_valid), 256'(0));
      end else begin
        chk("ex_payload", 256'({ex_rs_val, ex_rt_val, ex_imm, ex_br_target, ex_dest, ex_regwrite, ex_pc4}),
            256'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // reset
    set_instr(5'd1, 5'd0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", 256'(ex_valid), 256'(0));
    chk("rst_sb_err", 256'(sb_err), 256'(0));
    chk("rst_id_ready", 256'(id_ready), 256'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // seed r1, r2
    set_instr(5'd0, 5'd0, 16'h0004, 32'h100, 1'b0, 1'b0, 1'b1, 5'd1);
    cycle(1'b1, "seed_w1");
    set_instr(5'd0, 5'd0, 16'hFFFF, 32'h200, 1'b0, 1'b0, 1'b1, 5'd2);
    cycle(1'b1, "seed_w2");
    idle(); set_wb(1'b1, 5'd1, 32'h1111_1111);
    cycle(1'b1, "seed_wb1");
    set_wb(1'b1, 5'd2, 32'h2222_2222);
    cycle(1'b1, "seed_wb2");
    set_wb(1'b0, 5'd0, 32'h0);

    // back-to-back dependency on r5
    set_instr(5'd1, 5'd2, 16'h8000, 32'h1000, 1'b1, 1'b1, 1'b1, 5'd5);
    cycle(1'b1, "dep_w5");
    set_instr(5'd5, 5'd1, 16'h0010, 32'h1004, 1'b1, 1'b1, 1'b0, 5'd0);
    cycle(1'b0, "dep_stall_slot");
    cycle(1'b0, "dep_stall_cnt");
    set_wb(1'b1, 5'd5, 32'h0000_1234);
`ifdef DECODE_WB_BYPASS_EN
    cycle(1'b1, "dep_issue_bypass");
    set_wb(1'b0, 5'd0, 32'h0);
`else
    cycle(1'b0, "dep_stall_wb_cycle");
    set_wb(1'b0, 5'd0, 32'h0);
    cycle(1'b1, "dep_issue_after_wb");
`endif
    idle();
    cycle(1'b1, "dep_drain");

    // EX backpressure
    set_instr(5'd0, 5'd0, 16'h0001, 32'h2000, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle(1'b1, "bp_a");
    ex_ready = 1'b0;
    set_instr(5'd0, 5'd0, 16'h0002, 32'h2004, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall_ready", 256'(id_ready), 256'(0));
      chk("bp_hold_valid", 256'(ex_valid), 256'(1));
      chk("bp_hold_pc4", 256'(ex_pc4), 256'(32'h2000));
      chk("bp_hold_imm", 256'(ex_imm), 256'(32'h1));
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    cycle(1'b1, "bp_release_load");
    idle();
    @(negedge clk);
    chk("bp_b_loaded_pc4", 256'(ex_pc4), 256'(32'h2004));
    @(posedge clk); #1;

    // saturation on r7
    set_instr(5'd0, 5'd0, 16'h0, 32'h5000, 1'b0, 1'b0, 1'b1, 5'd7);
    cycle(1'b1, "sat_w7_1");
    cycle(1'b1, "sat_w7_2");
    cycle(1'b1, "sat_w7_3");
    cycle(1'b0, "sat_w7_4_pending");
    cycle(1'b0, "sat_w7_4_cnt3");
    set_wb(1'b1, 5'd7, 32'h70);
    cycle(1'b0, "sat_wb_cycle");
    set_wb(1'b0, 5'd0, 32'h0);
    cycle(1'b1, "sat_w7_4_issue");
    idle(); set_wb(1'b1, 5'd7, 32'h77);
    repeat (3) cycle(1'b1, "sat_drain");
    set_wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("sat_sb_err_clean", 256'(sb_err), 256'(0));
    @(posedge clk); #1;

    // inc and dec of r3 in the same cycle
    set_instr(5'd0, 5'd0, 16'h0, 32'h6000, 1'b0, 1'b0, 1'b1, 5'd3);
    cycle(1'b1, "net_w3a");
    idle();
    cycle(1'b1, "net_count");
    set_instr(5'd0, 5'd0, 16'h0, 32'h6004, 1'b0, 1'b0, 1'b1, 5'd3);
    cycle(1'b1, "net_w3b");
    idle(); set_wb(1'b1, 5'd3, 32'h33);
    cycle(1'b1, "net_inc_dec");
    set_wb(1'b0, 5'd0, 32'h0);
    set_instr(5'd3, 5'd0, 16'h0, 32'h6008, 1'b1, 1'b0, 1'b0, 5'd0);
    cycle(1'b0, "net_cnt_one");
    set_wb(1'b1, 5'd3, 32'h333);
`ifdef DECODE_WB_BYPASS_EN
    cycle(1'b1, "net_issue_bypass");
    set_wb(1'b0, 5'd0, 32'h0);
`else
    cycle(1'b0, "net_stall_wb_cycle");
    set_wb(1'b0, 5'd0, 32'h0);
    cycle(1'b1, "net_issue_after_wb");
`endif
    idle();
    cycle(1'b1, "net_drain");

    // release of a zero counter
    sb_release = 1'b1; sb_release_addr = 5'd9;
    cycle(1'b1, "rel_cycle");
    sb_release = 1'b0; sb_release_addr = '0;
    @(negedge clk);
    chk("sb_err_set", 256'(sb_err), 256'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_err_sticky", 256'(sb_err), 256'(1));
    @(posedge clk); #1;

    // flush
    set_instr(5'd0, 5'd0, 16'h0, 32'h3000, 1'b0, 1'b0, 1'b1, 5'd10);
    cycle(1'b1, "fl_load");
    ex_ready = 1'b0; flush = 1'b1;
    set_instr(5'd0, 5'd0, 16'h0, 32'h3004, 1'b0, 1'b0, 1'b1, 5'd4);
    cycle(1'b0, "fl_blocked");
    void'(exp_q.pop_front());
    flush = 1'b0; ex_ready = 1'b1; idle();
    @(negedge clk);
    chk("fl_killed_valid", 256'(ex_valid), 256'(0));
    chk("fl_no_load_pc4", 256'(ex_pc4), 256'(32'h3000));
    @(posedge clk); #1;
    set_instr(5'd10, 5'd4, 16'h0001, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 5'd0);
    cycle(1'b1, "fl_counters_untouched");
    idle();
    @(negedge clk);
    chk("br_target_wrap", 256'(ex_br_target), 256'(32'h0));
    @(posedge clk); #1;

    // reset mid-stream
    set_instr(5'd0, 5'd0, 16'h0, 32'h4000, 1'b0, 1'b0, 1'b1, 5'd6);
    cycle(1'b1, "mrst_w6");
    set_instr(5'd0, 5'd0, 16'h0, 32'h4004, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle(1'b1, "mrst_x");
    rst = 1'b1;
    #1;
    chk("mrst_ex_valid", 256'(ex_valid), 256'(0));
    chk("mrst_sb_err", 256'(sb_err), 256'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    set_instr(5'd1, 5'd6, 16'h0, 32'h4008, 1'b1, 1'b1, 1'b0, 5'd0);
    cycle(1'b1, "mrst_no_hazard");
    idle();
    cycle(1'b1, "mrst_drain");

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
